piso_tx: RTL and testbench

- Parallel-in/serial-out transmitter. It is the outbound counterpart of the team's parallel capture registers.
- Accepts a Width-bit word through a valid/ready handshake and shifts it out MSB-first, one bit per BitTicks clock cycles, qualified by a serial valid strobe.
- Sits between a parallel datapath and a serial link or LED/GPIO pin in the course designs.
- Pairs with a future serial-in/parallel-out receiver.

---
 rtl/piso_tx.sv | 99 +++++++++
 tb/tb_piso_tx.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: valid/ready word load, MSB-first shift-out with a valid strobe.
// Optional even-parity bit appended after the data bits when PISO_PARITY_EN is defined.
module piso_tx #(
    parameter int Width    = 8,
    parameter int BitTicks = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] d,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

`ifdef PISO_PARITY_EN
    localparam int FrameLen = Width + 1;
`else
    localparam int FrameLen = Width;
`endif
    localparam int CntW  = $clog2(FrameLen + 1);
    localparam int TickW = (BitTicks > 1) ? $clog2(BitTicks) : 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t              state, state_nxt;
    logic [FrameLen-1:0] shreg;
    logic [FrameLen-1:0] load_word;
    logic [CntW-1:0]     bit_cnt;
    logic [TickW-1:0]    tick_cnt;
    logic                done_q;
    logic                accept;
    logic                bit_end;
    logic                last_bit;

`ifdef PISO_PARITY_EN
    assign load_word = {d, ^d};
`else
    assign load_word = d;
`endif

    always_comb begin
        state_nxt  = state;
        load_ready = 1'b0;
        sout_valid = 1'b0;
        sout       = 1'b0;
        accept     = 1'b0;
        bit_end    = 1'b0;
        last_bit   = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                accept     = load_valid;
                if (accept) state_nxt = SHIFT;
            end
            SHIFT: begin
                sout_valid = 1'b1;
                sout       = shreg[FrameLen-1];
                bit_end    = (tick_cnt == TickW'(BitTicks - 1));
                last_bit   = bit_end && (bit_cnt == CntW'(FrameLen - 1));
                if (last_bit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign done = done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            tick_cnt <= '0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= last_bit;
            if (accept) begin
                shreg    <= load_word;
                bit_cnt  <= '0;
                tick_cnt <= '0;
            end else if (state == SHIFT) begin
                if (bit_end) begin
                    shreg    <= {shreg[FrameLen-2:0], 1'b0};
                    tick_cnt <= '0;
                    bit_cnt  <= bit_cnt + CntW'(1);
                end else begin
                    tick_cnt <= tick_cnt + TickW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: one instance at BitTicks=4, one at BitTicks=1.
// Frame-level vectors from a table plus hand sequences for held load_valid and mid-frame reset.
module tb_piso_tx;

`ifdef PISO_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d;
    logic       lv4, lv1;
    logic       rdy4, so4, sv4, dn4;
    logic       rdy1, so1, sv1, dn1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    piso_tx #(.Width(8), .BitTicks(4)) dut4 (
        .clk(clk), .rst(rst), .d(d), .load_valid(lv4),
        .load_ready(rdy4), .sout(so4), .sout_valid(sv4), .done(dn4)
    );

    piso_tx #(.Width(8), .BitTicks(1)) dut1 (
        .clk(clk), .rst(rst), .d(d), .load_valid(lv1),
        .load_ready(rdy1), .sout(so1), .sout_valid(sv1), .done(dn1)
    );

    typedef struct {
        bit         sel;    // 0: BitTicks=4 instance, 1: BitTicks=1 instance
        logic [7:0] dw;
        logic [7:0] eb;     // expected data bits, first transmitted on the left
        logic       ep;     // expected parity bit
        bit         hold;
        bit         chain;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic set_lv(input bit sel, input logic v);
        if (sel) lv1 = v;
        else     lv4 = v;
    endtask

    task automatic run_frame(input vec_t v);
        logic [8:0] seq;
        int         bt;
        seq = {v.eb, v.ep};
        bt  = v.sel ? 1 : 4;
        d   = v.dw;
        set_lv(v.sel, 1'b1);
        check("ready_before_accept", v.sel ? rdy1 : rdy4, 1'b1);
        step();
        if (v.hold) d = 8'hFF;
        else begin
            d = 8'h00;
            set_lv(v.sel, 1'b0);
        end
        for (int i = 0; i < FL; i++) begin
            for (int t = 0; t < bt; t++) begin
                check("sout_valid_in_frame", v.sel ? sv1 : sv4, 1'b1);
                check("sout_bit", v.sel ? so1 : so4, seq[8-i]);
                check("ready_low_in_frame", v.sel ? rdy1 : rdy4, 1'b0);
                check("done_low_in_frame", v.sel ? dn1 : dn4, 1'b0);
                step();
            end
        end
        check("done_pulse", v.sel ? dn1 : dn4, 1'b1);
        check("valid_low_at_done", v.sel ? sv1 : sv4, 1'b0);
        check("ready_at_done", v.sel ? rdy1 : rdy4, 1'b1);
        check("sout_low_at_done", v.sel ? so1 : so4, 1'b0);
        if (!v.chain) begin
            set_lv(v.sel, 1'b0);
            step();
            check("done_single_cycle", v.sel ? dn1 : dn4, 1'b0);
            check("valid_low_idle", v.sel ? sv1 : sv4, 1'b0);
            check("ready_idle", v.sel ? rdy1 : rdy4, 1'b1);
        end
    endtask

    initial begin
        rst = 1'b0;
        d   = 8'h00;
        lv4 = 1'b0;
        lv1 = 1'b0;

        //             sel  d      data bits     par   hold chain
        vecs[0] = '{1'b0, 8'hA5, 8'b10100101, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h81, 8'b10000001, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 8'h3C, 8'b00111100, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'hF0, 8'b11110000, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'h07, 8'b00000111, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 8'h03, 8'b00000011, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 8'h6B, 8'b01101011, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 8'hA5, 8'b10100101, 1'b0, 1'b1, 1'b0};

        step();
        step();
        check("rst_sout", so4, 1'b0);
        check("rst_valid", sv4, 1'b0);
        check("rst_done", dn4, 1'b0);
        check("rst_sout_bt1", so1, 1'b0);
        check("rst_valid_bt1", sv1, 1'b0);
        rst = 1'b1;
        step();
        check("ready_after_rst", rdy4, 1'b1);
        check("ready_after_rst_bt1", rdy1, 1'b1);

        for (int k = 0; k < 8; k++) run_frame(vecs[k]);

        // Mid-frame reset: the aborted frame must never produce done.
        d   = 8'hA5;
        lv4 = 1'b1;
        step();
        lv4 = 1'b0;
        for (int k = 0; k < 10; k++) step();
        check("midframe_valid_before_rst", sv4, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("abort_sout", so4, 1'b0);
        check("abort_valid", sv4, 1'b0);
        check("abort_done", dn4, 1'b0);
        step();
        rst = 1'b1;
        for (int k = 0; k < 40; k++) begin
            check("no_done_after_abort", dn4, 1'b0);
            check("idle_after_abort", sv4, 1'b0);
            check("ready_after_abort", rdy4, 1'b1);
            step();
        end

        // A fresh frame is still clean after the abort.
        run_frame(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
